// File: rtl/led_status_seq.sv
// LED status sequencer: queues dispense/change requests, runs timed LED holds and a fault state.
// Optional macro LED_SEQ_PREEMPT_EN lets fault_in abort a running hold.
module led_status_seq #(
    parameter int unsigned HOLD_DISP = 32'd40_000_000,
    parameter int unsigned HOLD_CHG  = 32'd20_000_000,
    parameter int unsigned CNT_W     = 32'd26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_disp,
    input  logic       req_chg,
    input  logic       fault_in,
    output logic [1:0] number_zhuangtai,
    output logic       busy,
    output logic       done,
    output logic       drop
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DISP  = 2'd1,
        ST_CHG   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(HOLD_DISP - 32'd1);
    localparam logic [CNT_W-1:0] CHG_LAST  = CNT_W'(HOLD_CHG - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_disp_q, pend_disp_d;
    logic             pend_chg_q, pend_chg_d;
    logic [1:0]       code_q, code_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    logic             want_disp_s;
    logic             want_chg_s;
    logic             hold_exit_s;
    logic             preempt_s;
    logic             enter_s;

    // Requests arriving on this edge count as pending alongside the stored flags.
    assign want_disp_s = pend_disp_q | req_disp;
    assign want_chg_s  = pend_chg_q | req_chg;
    assign hold_exit_s = ((state_q == ST_DISP) && (cnt_q == DISP_LAST)) ||
                         ((state_q == ST_CHG)  && (cnt_q == CHG_LAST));

`ifdef LED_SEQ_PREEMPT_EN
    assign preempt_s = fault_in;
`else
    assign preempt_s = 1'b0;
`endif

    function automatic state_t pick_next(input logic fault, input logic want_disp,
                                         input logic want_chg);
        state_t nxt;
        if (fault) begin
            nxt = ST_FAULT;
        end else if (want_disp) begin
            nxt = ST_DISP;
        end else if (want_chg) begin
            nxt = ST_CHG;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_disp_q <= 1'b0;
            pend_chg_q  <= 1'b0;
            code_q      <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_disp_q <= pend_disp_d;
            pend_chg_q  <= pend_chg_d;
            code_q      <= code_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = pick_next(fault_in, want_disp_s, want_chg_s);
            end
            ST_DISP, ST_CHG: begin
                if (preempt_s) begin
                    state_d = ST_FAULT;
                end else if (hold_exit_s) begin
                    state_d = pick_next(fault_in, want_disp_s, want_chg_s);
                end else begin
                    state_d = state_q;
                end
            end
            ST_FAULT: begin
                state_d = pick_next(fault_in, want_disp_s, want_chg_s);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold counter, pending flags and registered status outputs.
    always_comb begin
        // A hold exit re-enters a state even when it replays into the same one.
        enter_s = (state_d != state_q) | (hold_exit_s & ~preempt_s);

        if (enter_s) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (enter_s && (state_d == ST_DISP)) begin
            pend_disp_d = 1'b0;
        end else begin
            pend_disp_d = want_disp_s;
        end

        if (enter_s && (state_d == ST_CHG)) begin
            pend_chg_d = 1'b0;
        end else begin
            pend_chg_d = want_chg_s;
        end

        case (state_d)
            ST_IDLE:  code_d = 2'b00;
            ST_DISP:  code_d = 2'b11;
            ST_CHG:   code_d = 2'b01;
            ST_FAULT: code_d = 2'b01;
            default:  code_d = 2'b00;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = hold_exit_s & ~preempt_s;
        drop_d = (req_disp & pend_disp_q) | (req_chg & pend_chg_q);
    end

    assign number_zhuangtai = code_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign drop             = drop_q;

endmodule

// File: tb/tb_led_status_seq.sv
// Directed self-checking bench for led_status_seq with HOLD_DISP=8, HOLD_CHG=4.
module tb_led_status_seq;

    logic       clk;
    logic       rst;
    logic       req_disp;
    logic       req_chg;
    logic       fault_in;
    logic [1:0] number_zhuangtai;
    logic       busy;
    logic       done;
    logic       drop;

    int n_checks;
    int n_fail;

    led_status_seq #(
        .HOLD_DISP(32'd8),
        .HOLD_CHG (32'd4),
        .CNT_W    (32'd26)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_disp        (req_disp),
        .req_chg         (req_chg),
        .fault_in        (fault_in),
        .number_zhuangtai(number_zhuangtai),
        .busy            (busy),
        .done            (done),
        .drop            (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_disp = 1'b1; req_chg = 1'b0; fault_in = 1'b0;
        step();
        step();
        rst = 1'b0; req_disp = 1'b0;
        n_checks++;
        if ({number_zhuangtai, busy, done, drop} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset: got code=%b busy=%b done=%b drop=%b, expected 00000",
                     number_zhuangtai, busy, done, drop);
        end
        step();
        n_checks++;
        if ({number_zhuangtai, busy, done, drop} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ignored_req: got code=%b busy=%b done=%b drop=%b, expected 00000",
                     number_zhuangtai, busy, done, drop);
        end
    endtask

    task automatic test_single_disp();
        logic [4:0] exp;
        req_disp = 1'b1;
        step();
        req_disp = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp = {(c <= 8) ? 2'b11 : 2'b00, 1'(c <= 8), 1'(c == 9), 1'b0};
            n_checks++;
            if ({number_zhuangtai, busy, done, drop} !== exp) begin
                n_fail++;
                $display("FAIL single_disp cycle %0d: got %b%b%b%b, expected %b",
                         c, number_zhuangtai, busy, done, drop, exp);
            end
            step();
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp;
        logic [1:0] code;
        req_disp = 1'b1; req_chg = 1'b1;
        step();
        req_disp = 1'b0; req_chg = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            code = (c <= 8) ? 2'b11 : ((c <= 12) ? 2'b01 : 2'b00);
            exp = {code, 1'(c <= 12), 1'((c == 9) || (c == 13)), 1'b0};
            n_checks++;
            if ({number_zhuangtai, busy, done, drop} !== exp) begin
                n_fail++;
                $display("FAIL simultaneous cycle %0d: got %b%b%b%b, expected %b",
                         c, number_zhuangtai, busy, done, drop, exp);
            end
            step();
        end
    endtask

    task automatic test_drop();
        logic [4:0] exp;
        logic [1:0] code;
        req_disp = 1'b1;
        step();
        req_disp = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            code = (c <= 8) ? 2'b11 : ((c <= 12) ? 2'b01 : 2'b00);
            exp = {code, 1'(c <= 12), 1'((c == 9) || (c == 13)), 1'(c == 5)};
            n_checks++;
            if ({number_zhuangtai, busy, done, drop} !== exp) begin
                n_fail++;
                $display("FAIL drop cycle %0d: got %b%b%b%b, expected %b",
                         c, number_zhuangtai, busy, done, drop, exp);
            end
            req_chg = ((c == 2) || (c == 4));
            step();
        end
        req_chg = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        req_disp = 1'b1;
        step();
        req_disp = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            exp = {(c <= 16) ? 2'b11 : 2'b00, 1'(c <= 16), 1'((c == 9) || (c == 17)), 1'b0};
            n_checks++;
            if ({number_zhuangtai, busy, done, drop} !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b%b%b%b, expected %b",
                         c, number_zhuangtai, busy, done, drop, exp);
            end
            req_disp = (c == 5);
            step();
        end
        req_disp = 1'b0;
    endtask

    task automatic test_fault_during_disp();
        logic [4:0] exp;
        logic [1:0] code;
        logic       dn;
        req_disp = 1'b1;
        step();
        req_disp = 1'b0;
        for (int c = 1; c <= 13; c++) begin
`ifdef LED_SEQ_PREEMPT_EN
            code = (c <= 3) ? 2'b11 : ((c <= 11) ? 2'b01 : 2'b00);
            dn   = 1'b0;
`else
            code = (c <= 8) ? 2'b11 : ((c <= 11) ? 2'b01 : 2'b00);
            dn   = (c == 9);
`endif
            exp = {code, 1'(c <= 11), dn, 1'b0};
            n_checks++;
            if ({number_zhuangtai, busy, done, drop} !== exp) begin
                n_fail++;
                $display("FAIL fault_during_disp cycle %0d: got %b%b%b%b, expected %b",
                         c, number_zhuangtai, busy, done, drop, exp);
            end
            fault_in = ((c >= 3) && (c <= 10));
            step();
        end
        fault_in = 1'b0;
    endtask

    task automatic test_fault_idle();
        logic [4:0] exp;
        fault_in = 1'b1;
        step();
        for (int c = 1; c <= 9; c++) begin
            exp = {(c <= 7) ? 2'b01 : 2'b00, 1'(c <= 7), 1'(c == 8), 1'b0};
            n_checks++;
            if ({number_zhuangtai, busy, done, drop} !== exp) begin
                n_fail++;
                $display("FAIL fault_idle cycle %0d: got %b%b%b%b, expected %b",
                         c, number_zhuangtai, busy, done, drop, exp);
            end
            fault_in = (c <= 2);
            req_chg  = (c == 1);
            step();
        end
        fault_in = 1'b0; req_chg = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] exp;
        req_chg = 1'b1;
        step();
        req_chg = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp = {(c <= 3) ? 2'b01 : 2'b00, 1'(c <= 3), 1'b0, 1'b0};
            n_checks++;
            if ({number_zhuangtai, busy, done, drop} !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_hold cycle %0d: got %b%b%b%b, expected %b",
                         c, number_zhuangtai, busy, done, drop, exp);
            end
            req_disp = ((c == 1) || (c == 3));
            rst      = (c == 3);
            step();
        end
        req_disp = 1'b0; rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_disp();
        test_simultaneous();
        test_drop();
        test_back_to_back();
        test_fault_during_disp();
        test_fault_idle();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
